// File: rtl/second_game_pkg.sv
// Shared types and widths for the second-game controller slice.
package second_game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CRASH = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam int unsigned DEF_WIDTH  = 400;
    localparam int unsigned DEF_HEIGHT = 600;
    localparam int unsigned X_W        = $clog2(DEF_WIDTH);
    localparam int unsigned SCROLL_W   = $clog2(DEF_HEIGHT);
    localparam int unsigned SCORE_W    = 16;
    localparam int unsigned SPEED_W    = 4;
    localparam int unsigned H_W        = 11;
    localparam int unsigned V_W        = 10;
    localparam int unsigned CMP_W      = 12;

    function automatic logic [CMP_W-1:0] abs_cmp(input logic signed [CMP_W-1:0] v);
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/second_game_ctrl_if.sv
// Pixel-stream, frame-control and game-output bundle for second_game_ctrl.
interface second_game_ctrl_if
    import second_game_pkg::*;
#(
    parameter int unsigned SECOND_GAME_SCREEN_WIDTH  = DEF_WIDTH,
    parameter int unsigned SECOND_GAME_SCREEN_HEIGHT = DEF_HEIGHT
);
    localparam int unsigned XW = $clog2(SECOND_GAME_SCREEN_WIDTH);
    localparam int unsigned SW = $clog2(SECOND_GAME_SCREEN_HEIGHT);

    logic               i_frame_tick;
    logic               i_start;
    logic               i_btn_left;
    logic               i_btn_right;
    logic               i_disp_enbl;
    logic [H_W-1:0]     i_h_coord;
    logic [V_W-1:0]     i_v_coord;
    logic               i_is_obstacle;
    logic [XW-1:0]      o_screen_square_x;
    logic [SW-1:0]      o_scroll_y;
    logic [SPEED_W-1:0] o_speed;
    logic [SCORE_W-1:0] o_score;
    logic [1:0]         o_state;
    logic               o_crash;

    modport master (
        output i_frame_tick, i_start, i_btn_left, i_btn_right,
               i_disp_enbl, i_h_coord, i_v_coord, i_is_obstacle,
        input  o_screen_square_x, o_scroll_y, o_speed, o_score, o_state, o_crash
    );

    modport slave (
        input  i_frame_tick, i_start, i_btn_left, i_btn_right,
               i_disp_enbl, i_h_coord, i_v_coord, i_is_obstacle,
        output o_screen_square_x, o_scroll_y, o_speed, o_score, o_state, o_crash
    );
endinterface

// File: rtl/second_game_collision.sv
// Windowed player/obstacle overlap test on the pixel stream with a per-frame sticky flag.
module second_game_collision
    import second_game_pkg::*;
#(
    parameter int unsigned SECOND_GAME_PLAYER_SIZE = 20,
    parameter int unsigned SECOND_GAME_PLAYER_Y    = 10,
    parameter int unsigned PX_W                    = X_W
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_frame_tick,
    input  logic            i_disp_enbl,
    input  logic            i_is_obstacle,
    input  logic [H_W-1:0]  i_h_coord,
    input  logic [V_W-1:0]  i_v_coord,
    input  logic [PX_W-1:0] i_player_x,
    output logic            o_hit
);
    localparam logic [CMP_W-1:0] SIZE = CMP_W'(SECOND_GAME_PLAYER_SIZE);

    logic signed [CMP_W-1:0] dh;
    logic signed [CMP_W-1:0] dv;
    logic                    hit;

    always_comb begin
        dh  = signed'({1'b0, i_h_coord}) - signed'(CMP_W'(i_player_x));
        dv  = signed'({2'b00, i_v_coord}) - signed'(CMP_W'(SECOND_GAME_PLAYER_Y));
        hit = i_disp_enbl && i_is_obstacle && (abs_cmp(dh) <= SIZE) && (abs_cmp(dv) <= SIZE);
    end

    // The tick cycle's own hit seeds the next frame's flag instead of being lost.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_hit <= 1'b0;
        else if (i_frame_tick)
            o_hit <= hit;
        else
            o_hit <= o_hit | hit;
    end
endmodule

// File: rtl/second_game_ctrl.sv
// Frame-rate controller for the second game: FSM, player X, scroll, speed, score.
// Optional speed ramp is enabled by defining SECOND_GAME_SPEEDUP_EN.
module second_game_ctrl
    import second_game_pkg::*;
#(
    parameter int unsigned SECOND_GAME_SCREEN_WIDTH  = DEF_WIDTH,
    parameter int unsigned SECOND_GAME_SCREEN_HEIGHT = DEF_HEIGHT,
    parameter int unsigned SECOND_GAME_PLAYER_SIZE   = 20,
    parameter int unsigned SECOND_GAME_PLAYER_Y      = 10,
    parameter int unsigned PLAYER_STEP               = 4,
    parameter int unsigned INIT_SPEED                = 1,
    parameter int unsigned MAX_SPEED                 = 8,
    parameter int unsigned SPEEDUP_FRAMES            = 300,
    parameter int unsigned CRASH_FRAMES              = 60
) (
    input  logic              i_clk,
    input  logic              i_rst,
    second_game_ctrl_if.slave bus
);
    localparam int unsigned XW      = $clog2(SECOND_GAME_SCREEN_WIDTH);
    localparam int unsigned SW      = $clog2(SECOND_GAME_SCREEN_HEIGHT);
    localparam int unsigned CRASH_W = $clog2(CRASH_FRAMES + 1);

    localparam logic signed [CMP_W-1:0] X_MIN  = CMP_W'(SECOND_GAME_PLAYER_SIZE);
    localparam logic signed [CMP_W-1:0] X_MAX  =
        CMP_W'(SECOND_GAME_SCREEN_WIDTH - 1 - SECOND_GAME_PLAYER_SIZE);
    localparam logic signed [CMP_W-1:0] STEP_S = CMP_W'(PLAYER_STEP);
    localparam logic [XW-1:0]           X_INIT = XW'(SECOND_GAME_SCREEN_WIDTH / 2);
    localparam logic [SW:0]             HEIGHT = (SW + 1)'(SECOND_GAME_SCREEN_HEIGHT);

    game_state_t             state, state_next;
    logic [XW-1:0]           x, x_next;
    logic [SW-1:0]           scroll, scroll_next;
    logic [SCORE_W-1:0]      score, score_next;
    logic [CRASH_W-1:0]      crash_cnt, crash_cnt_next;
    logic [SPEED_W-1:0]      speed;
    logic                    crash;
    logic                    hit_flag;
    logic signed [CMP_W-1:0] x_move;
    logic [SW:0]             scroll_sum;

    second_game_collision #(
        .SECOND_GAME_PLAYER_SIZE (SECOND_GAME_PLAYER_SIZE),
        .SECOND_GAME_PLAYER_Y    (SECOND_GAME_PLAYER_Y),
        .PX_W                    (XW)
    ) u_collision (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_frame_tick  (bus.i_frame_tick),
        .i_disp_enbl   (bus.i_disp_enbl),
        .i_is_obstacle (bus.i_is_obstacle),
        .i_h_coord     (bus.i_h_coord),
        .i_v_coord     (bus.i_v_coord),
        .i_player_x    (x),
        .o_hit         (hit_flag)
    );

    always_comb begin
        state_next     = state;
        x_next         = x;
        scroll_next    = scroll;
        score_next     = score;
        crash_cnt_next = crash_cnt;

        x_move = signed'(CMP_W'(x));
        if (bus.i_btn_left && !bus.i_btn_right)
            x_move = x_move - STEP_S;
        else if (bus.i_btn_right && !bus.i_btn_left)
            x_move = x_move + STEP_S;
        if (x_move < X_MIN)
            x_move = X_MIN;
        else if (x_move > X_MAX)
            x_move = X_MAX;

        // One extra bit keeps scroll+speed exact before the modulo subtract.
        scroll_sum = {1'b0, scroll} + (SW + 1)'(speed);
        if (scroll_sum >= HEIGHT)
            scroll_sum = scroll_sum - HEIGHT;

        if (bus.i_frame_tick) begin
            case (state)
                IDLE: begin
                    if (bus.i_start)
                        state_next = PLAY;
                end
                PLAY: begin
                    if (hit_flag) begin
                        state_next = CRASH;
                    end else begin
                        x_next      = x_move[XW-1:0];
                        scroll_next = scroll_sum[SW-1:0];
                        score_next  = (score == '1) ? score : score + SCORE_W'(1);
                    end
                end
                CRASH: begin
                    if (crash_cnt == CRASH_W'(CRASH_FRAMES - 1)) begin
                        state_next     = OVER;
                        crash_cnt_next = '0;
                    end else begin
                        crash_cnt_next = crash_cnt + CRASH_W'(1);
                    end
                end
                OVER: begin
                    if (bus.i_start) begin
                        state_next  = IDLE;
                        x_next      = X_INIT;
                        scroll_next = '0;
                        score_next  = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            x         <= X_INIT;
            scroll    <= '0;
            score     <= '0;
            crash_cnt <= '0;
            crash     <= 1'b0;
        end else begin
            state     <= state_next;
            x         <= x_next;
            scroll    <= scroll_next;
            score     <= score_next;
            crash_cnt <= crash_cnt_next;
            crash     <= (state_next == CRASH);
        end
    end

`ifdef SECOND_GAME_SPEEDUP_EN
    localparam int unsigned RAMP_W = $clog2(SPEEDUP_FRAMES);

    logic [RAMP_W-1:0]  ramp, ramp_next;
    logic [SPEED_W-1:0] speed_next;

    always_comb begin
        ramp_next  = ramp;
        speed_next = speed;
        if (bus.i_frame_tick && (state == PLAY) && !hit_flag) begin
            if (ramp == RAMP_W'(SPEEDUP_FRAMES - 1)) begin
                ramp_next = '0;
                if (speed < SPEED_W'(MAX_SPEED))
                    speed_next = speed + SPEED_W'(1);
            end else begin
                ramp_next = ramp + RAMP_W'(1);
            end
        end else if (bus.i_frame_tick && (state == OVER) && bus.i_start) begin
            ramp_next  = '0;
            speed_next = SPEED_W'(INIT_SPEED);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ramp  <= '0;
            speed <= SPEED_W'(INIT_SPEED);
        end else begin
            ramp  <= ramp_next;
            speed <= speed_next;
        end
    end
`else
    assign speed = SPEED_W'(INIT_SPEED);
`endif

    assign bus.o_screen_square_x = x;
    assign bus.o_scroll_y        = scroll;
    assign bus.o_speed           = speed;
    assign bus.o_score           = score;
    assign bus.o_state           = state;
    assign bus.o_crash           = crash;
endmodule
